// File: rtl/onehot_req_sched_pkg.sv
// rtl/onehot_req_sched_pkg.sv - shared constants and FSM encoding for the one-hot request scheduler
package onehot_req_sched_pkg;

  localparam int N  = 8;
  localparam int PW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

endpackage

// File: rtl/onehot_req_sched_rr_pick8.sv
// rtl/onehot_req_sched_rr_pick8.sv - round-robin pick of the first pending bit at or after ptr
module rr_pick8
  import onehot_req_sched_pkg::*;
(
  input  logic [N-1:0]  pending,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant_onehot,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   rot_grant;
  logic [2*N-1:0] back;
  logic [PW-1:0]  off;

  always_comb begin
    // rot[i] holds pending[(ptr+i) mod N], so bit 0 is the highest priority
    dbl       = {pending, pending};
    rot       = dbl[ptr +: N];
    rot_grant = rot & (~rot + N'(1));
    back      = {rot_grant, rot_grant} << ptr;
    off       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = PW'(i);
    end
    any          = |pending;
    grant_onehot = back[2*N-1:N];
    grant_idx    = off + ptr;
  end

endmodule

// File: rtl/onehot_req_sched.sv
// rtl/onehot_req_sched.sv - edge-captured requests presented one-hot, round-robin, under valid/ready
module onehot_req_sched
  import onehot_req_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_in,
  input  logic         out_ready,
  input  logic         clr_ovf,
  output logic         out_valid,
  output logic [N-1:0] onehot,
  output logic [N-1:0] pending,
  output logic [N-1:0] ovf
);

  logic [N-1:0]  s1, s2, prev;
  logic [N-1:0]  rise, acc_mask, pending_next, ovf_next;
  logic [N-1:0]  onehot_next, pick_oh;
  logic [PW-1:0] ptr, ptr_next, gidx, gidx_next, pick_idx;
  logic          accept, pick_any;
  state_t        state, state_next;

  assign rise         = s2 & ~prev;
  assign out_valid    = (state == OFFER);
  assign accept       = out_valid & out_ready;
  assign acc_mask     = accept ? onehot : '0;
  // a new edge on the bit being accepted re-sets it and does not count as overflow
  assign pending_next = (pending & ~acc_mask) | rise;
  assign ovf_next     = (clr_ovf ? '0 : ovf) | (rise & pending & ~acc_mask);
  assign ptr_next     = accept ? gidx + PW'(1) : ptr;

  rr_pick8 u_pick (
    .pending      (pending_next),
    .ptr          (ptr_next),
    .grant_onehot (pick_oh),
    .grant_idx    (pick_idx),
    .any          (pick_any)
  );

  always_comb begin
    state_next  = state;
    onehot_next = onehot;
    gidx_next   = gidx;
    case (state)
      IDLE: begin
        if (|pending) begin
          state_next  = OFFER;
          onehot_next = pick_oh;
          gidx_next   = pick_idx;
        end
      end
      OFFER: begin
        if (out_ready) begin
          if (pick_any) begin
            onehot_next = pick_oh;
            gidx_next   = pick_idx;
          end else begin
            state_next  = IDLE;
            onehot_next = '0;
          end
        end
      end
      default: begin
        state_next  = IDLE;
        onehot_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1      <= '0;
      s2      <= '0;
      prev    <= '0;
      pending <= '0;
      ovf     <= '0;
      ptr     <= '0;
      gidx    <= '0;
      onehot  <= '0;
      state   <= IDLE;
    end else begin
      s1      <= req_in;
      s2      <= s1;
      prev    <= s2;
      pending <= pending_next;
      ovf     <= ovf_next;
      ptr     <= ptr_next;
      gidx    <= gidx_next;
      onehot  <= onehot_next;
      state   <= state_next;
    end
  end

endmodule
